// File: rtl/mips_defs.sv
// Shared MIPS opcode/funct encodings and the Tuse/Tnew timing vocabulary
// used by the hazard controller and its instruction classifier.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // A source read too early for a producer that has not yet produced: stall.
  function automatic logic reg_hazard(input logic [4:0] a3, input logic [4:0] src,
                                      input logic [1:0] tuse, input logic [1:0] tnew);
    return (a3 != 5'd0) && (a3 == src) && (tuse != TUSE_NONE) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational classifier: maps one instruction word to its register
// timing (Tuse per source, Tnew in E) and its mult/div and HI/LO roles.
module instr_class
  import mips_defs::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  rs_tuse,
  output logic [1:0]  rt_tuse,
  output logic [1:0]  tnew_e,
  output logic        is_md_start,
  output logic        is_div,
  output logic        is_hilo
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign fn          = instr[5:0];
  assign unused_bits = ^instr[25:6];

  // Anything not listed falls through to the defaults, i.e. behaves as a nop.
  always_comb begin
    rs_tuse     = TUSE_NONE;
    rt_tuse     = TUSE_NONE;
    tnew_e      = TNEW_0;
    is_md_start = 1'b0;
    is_div      = 1'b0;
    is_hilo     = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU: begin
            rs_tuse = TUSE_1;
            rt_tuse = TUSE_1;
            tnew_e  = TNEW_1;
          end
          FN_JR: rs_tuse = TUSE_0;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            rs_tuse     = TUSE_1;
            rt_tuse     = TUSE_1;
            is_md_start = 1'b1;
            is_div      = (fn == FN_DIV) || (fn == FN_DIVU);
            is_hilo     = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            tnew_e  = TNEW_1;
            is_hilo = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            rs_tuse = TUSE_1;
            is_hilo = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        rs_tuse = TUSE_1;
        tnew_e  = TNEW_1;
      end
      OP_LW: begin
        rs_tuse = TUSE_1;
        tnew_e  = TNEW_2;
      end
      OP_SW: begin
        rs_tuse = TUSE_1;
        rt_tuse = TUSE_2;
      end
      OP_BEQ: begin
        rs_tuse = TUSE_0;
        rt_tuse = TUSE_0;
      end
      OP_LUI, OP_JAL, OP_J: tnew_e = TNEW_0;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall controller: compares D-stage source timing against E/M
// producers and holds HI/LO users in D while the mult/div unit is busy.
module hazard_ctrl
  import mips_defs::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] InstrE,
  input  logic [31:0] InstrM,
  input  logic [4:0]  A3E,
  input  logic [4:0]  A3M,
  output logic        PCEn,
  output logic        DRegEn,
  output logic        ERegFlush,
  output logic        MDBusy
);

  logic [1:0] rs_tuse_d, rt_tuse_d, tnew_e_d;
  logic       md_start_d, is_div_d, is_hilo_d;
  logic [1:0] rs_tuse_e, rt_tuse_e, tnew_e;
  logic       md_start_e, is_div_e, is_hilo_e;
  logic [1:0] rs_tuse_m, rt_tuse_m, tnew_e_m;
  logic       md_start_m, is_div_m, is_hilo_m;

  logic [1:0]       tnew_m;
  logic [4:0]       rs_d, rt_d;
  logic             hazard_e, hazard_m, md_stall, stall;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             unused_sig;

  instr_class u_cls_d (
    .instr(InstrD), .rs_tuse(rs_tuse_d), .rt_tuse(rt_tuse_d), .tnew_e(tnew_e_d),
    .is_md_start(md_start_d), .is_div(is_div_d), .is_hilo(is_hilo_d)
  );

  instr_class u_cls_e (
    .instr(InstrE), .rs_tuse(rs_tuse_e), .rt_tuse(rt_tuse_e), .tnew_e(tnew_e),
    .is_md_start(md_start_e), .is_div(is_div_e), .is_hilo(is_hilo_e)
  );

  instr_class u_cls_m (
    .instr(InstrM), .rs_tuse(rs_tuse_m), .rt_tuse(rt_tuse_m), .tnew_e(tnew_e_m),
    .is_md_start(md_start_m), .is_div(is_div_m), .is_hilo(is_hilo_m)
  );

  assign unused_sig = ^{tnew_e_d, md_start_d, is_div_d, rs_tuse_e, rt_tuse_e, is_hilo_e,
                        rs_tuse_m, rt_tuse_m, md_start_m, is_div_m, is_hilo_m};

  assign rs_d   = InstrD[25:21];
  assign rt_d   = InstrD[20:16];
  // Only a load still has a result outstanding once it reaches M.
  assign tnew_m = (tnew_e_m == TNEW_2) ? TNEW_1 : TNEW_0;

  always_comb begin
    hazard_e = reg_hazard(A3E, rs_d, rs_tuse_d, tnew_e) ||
               reg_hazard(A3E, rt_d, rt_tuse_d, tnew_e);
    hazard_m = reg_hazard(A3M, rs_d, rs_tuse_d, tnew_m) ||
               reg_hazard(A3M, rt_d, rt_tuse_d, tnew_m);
    md_stall = is_hilo_d && ((cnt_q != '0) || md_start_e);
    stall    = hazard_e || hazard_m || md_stall;
  end

  // A fresh mult/div in E reloads the counter even if it is still running.
  always_comb begin
    cnt_d = cnt_q;
    if (md_start_e)
      cnt_d = is_div_e ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign PCEn      = ~stall;
  assign DRegEn    = ~stall;
  assign ERegFlush = stall;
  assign MDBusy    = (cnt_q != '0);

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard/stall controller for the 5-stage MIPS pipeline. It drives the F/D hold enables and the flush into the D->E pipeline register.
- Decodes the instructions in D, E and M into Tuse/Tnew and stalls D on any hazard that forwarding cannot resolve.
- Tracks the multi-cycle mult/div unit with a busy counter, so HI/LO instructions in D wait until the unit is idle.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu leaves E
- DIV_CYC, 10, busy cycles after a div/divu leaves E
- CNT_W, 4, busy counter width; must hold max(MULT_CYC, DIV_CYC)

Ports:
- Clk  input  1  clock
- Reset  input  1  synchronous, active-high reset
- InstrD  input  32  instruction in D
- InstrE  input  32  instruction in E
- InstrM  input  32  instruction in M
- A3E  input  5  destination register of E instr (0 = none)
- A3M  input  5  destination register of M instr (0 = none)
- PCEn  output  1  PC write enable (0 = hold F)
- DRegEn  output  1  F->D register enable (0 = hold D)
- ERegFlush  output  1  clear D->E register (insert bubble)
- MDBusy  output  1  mult/div unit busy (counter != 0)

Behaviour:
- Reset and clock: Reset and clock are synchronous, active-high Reset on Clk. Reset clears the busy counter to 0, so MDBusy=0 and Stall=0 unless the D/E/M inputs alone demand it.
- Outputs: Stall is combinational. PCEn = DRegEn = ~Stall, ERegFlush = Stall. While Stall=1, F and D hold and a nop enters E.
- Supported set: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo, nop (all-zero word).
- Unknown encodings are decoded as nop: no use, no write.
- Tuse of the D instruction, rs field:
  - beq, jr: 0.
  - addu, subu, ori, lw, sw, mult*, div*, mthi, mtlo: 1.
  - All others: none.
- Tuse of the D instruction, rt field:
  - beq: 0.
  - addu, subu, mult*, div*: 1.
  - sw: 2.
  - All others: none.
- Tnew in E:
  - lw: 2.
  - addu, subu, ori, mfhi, mflo: 1.
  - lui, jal: 0 (result computed in D).
  - All others: 0.
- Tnew in M: lw 1, else 0.
- Register hazard (E): A3E != 0, A3E equals a used D source field, and Tuse < TnewE.
- Register hazard (M): same rule using A3M and TnewM.
- Register $0 never causes a stall.
- MD start: InstrE is mult, multu, div or divu.
  - At the next posedge the counter loads MULT_CYC (mult/multu) or DIV_CYC (div/divu).
  - Otherwise, if counter != 0, it decrements by 1. It never wraps below 0.
- MD stall: InstrD is mult*, div*, mfhi, mflo, mthi or mtlo, and (MDBusy or MD start in E).
- Stall = any E hazard, or any M hazard, or MD stall.
- Simultaneous MD start in E and a nonzero counter: the load wins. The pipeline cannot produce this case, but the bench forces it.
- Reset mid-busy: the counter is 0 on the cycle after Reset, with no residual stall.
- Bubble on flush: a bubble (InstrE=0) never starts the MD counter and never matches A3E=0.

Decomposition:
- Shared package mips_defs:
  - opcode and funct localparams: OP_RTYPE, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL; FN_ADDU, FN_SUBU, FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO.
  - Tuse/Tnew encoding constants (2-bit; "none" = 3 for Tuse).
- One sub-module, instr_class: combinational decoder from a 32-bit Instr to rs_tuse, rt_tuse, tnew_e, is_md_start, is_hilo.
  - Instantiated three times, for D, E and M.

Test Plan:
- Load-use: InstrE=lw $8,0($0) with A3E=8, InstrD=addu $9,$8,$8 -> Stall=1 (PCEn=0, DRegEn=0, ERegFlush=1) for 1 cycle. Next cycle: lw in M with A3M=8 and a bubble in E -> Stall=0.
- Branch on ALU result: InstrE=addu $5,$1,$2 with A3E=5, InstrD=beq $5,$0,x -> Stall=1. After the instr moves to M (TnewM=0) -> Stall=0. Same case with A3E=0 -> Stall=0.
- sw data after lw: InstrE=lw $4, InstrD=sw $4,0($1) (rt Tuse=2, TnewE=2) -> Stall=0. InstrE=lw $4, InstrD=sw $1,0($4) -> Stall=1.
- Mult busy: mult in E at cycle 0, mflo in D at cycle 1 -> Stall=1 for cycles 1..5 (MDBusy=1), Stall=0 at cycle 6. div instead -> Stall released at cycle 11.
- Reset mid-busy: div in E, Reset asserted at cycle 3 -> MDBusy=0 at cycle 4, and mfhi in D is not stalled.
- No false stalls: jal in E (A3E=31) with jr $31 in D -> Stall=0. nop in E/M with any D instr -> Stall=0.
